// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the fetch (IF)
// and memory-access (MA) ports, with MA priority bounded by a starvation count.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic [DATA_W-1:0] ma_rdata,
  output logic              ma_valid,
  output logic              ma_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        starve_q;
  logic              grant_ma_q;
  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ma_rdata_q;
  logic              any_req;
  logic              ma_wins;

  assign any_req = if_req | ma_req;
  // MA holds the older instruction, so it wins unless IF has waited too long.
  assign ma_wins = ma_req & (~if_req | (starve_q < STARVE_LIM));

  always_comb begin
    // NOTE: state_d gets a default before the case so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      grant_ma_q  <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      if_rdata_q  <= '0;
      ma_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_ma_q <= ma_wins;
            lat_addr_q <= ma_wins ? ma_addr : if_addr;
            lat_we_q   <= ma_wins & ma_we;
            if (ma_wins) lat_wdata_q <= ma_wdata;
            if (ma_wins && if_req)
              starve_q <= (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
            else
              starve_q <= '0;
          end
        end
        ISSUE: cnt_q <= LAT_LOAD;
        WAIT: begin
          if (cnt_q == 4'd0) begin
            // Stores leave the read-data registers untouched.
            if (!lat_we_q) begin
              if (grant_ma_q) ma_rdata_q <= mem_rdata;
              else            if_rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & lat_we_q;
  assign mem_addr  = lat_addr_q;
  assign mem_wdata = lat_wdata_q;

  assign if_valid  = (state_q == RESP) & ~grant_ma_q;
  assign ma_valid  = (state_q == RESP) &  grant_ma_q;
  assign if_rdata  = if_rdata_q;
  assign ma_rdata  = ma_rdata_q;

  assign if_stall  = if_req & ~if_valid;
  assign ma_stall  = ma_req & ~ma_valid;

endmodule
